stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Run-control sequencer for the millisecond stopwatch datapath (prescaler-driven counter plus 7-segment scan). Debounces the start/stop, lap and clear pushbuttons. Runs a start/pause/lap/done FSM, generates the gated 1 kHz count tick, and drives the counter's clear and the display's freeze (lap hold) controls. Sits between the board buttons and the counter/display datapath.

Parameters:
TICK_DIV, 100000, clk cycles per count tick (100 MHz -> 1 ms)
DB_CYC, 1000000, stable-level cycles required to accept a button change (10 ms)
LAP_HOLD_TICKS, 3000, ticks a lap freeze lasts before auto-release (used only with the optional feature)

Ports:
clk  in  1  100 MHz system clock
reset  in  1  asynchronous, active-low reset
btn_start  in  1  raw start/stop button, asynchronous, active-high
btn_lap  in  1  raw lap button, asynchronous, active-high
btn_clr  in  1  raw clear button, asynchronous, active-high
cnt_at_max  in  1  datapath count equals its maximum (e.g. 9999)
cnt_tick  out  1  one-cycle increment enable to the counter
cnt_clr  out  1  one-cycle synchronous clear to the counter
disp_hold  out  1  level; display latches and shows frozen value while high
state  out  3  encoded FSM state (IDLE=0, RUN=1, PAUSE=2, LAP=3, DONE=4)
running  out  1  high in RUN or LAP

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-low. All flops clear when reset is low.
- Reset values: state=IDLE, cnt_tick=0, cnt_clr=0, disp_hold=0, running=0, prescaler=0, debouncers=0, synchronizers=0.
- Input conditioning, per button:
  - 2-flop synchronizer, then debounce counter.
  - The debounced level changes only after the synced input differs from it for DB_CYC consecutive cycles. Any mismatch gap restarts the count.
  - A press pulse (1 cycle) fires on the debounced 0->1 transition. Releases generate nothing.
  - Latency from stable raw press to pulse: 2 + DB_CYC cycles.
- Simultaneous pulses in one cycle: clr wins over start, and start wins over lap. Lower-priority pulses that cycle are discarded.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN or LAP. Holds its value in PAUSE.
  - Forced to 0 in IDLE and DONE.
  - Internal tick = (prescaler == TICK_DIV-1) in RUN/LAP.
- FSM transitions:
  - IDLE: start -> RUN. lap ignored. clr -> IDLE and pulses cnt_clr.
  - RUN: start -> PAUSE. lap -> LAP. clr -> IDLE + cnt_clr. Internal tick with cnt_at_max=1 -> DONE, and cnt_tick is suppressed.
  - LAP: counting continues (cnt_tick as RUN) and disp_hold=1. lap -> RUN (display live). start -> PAUSE with disp_hold released. clr -> IDLE + cnt_clr. Tick at max -> DONE.
  - PAUSE: start -> RUN, with the fractional prescaler preserved. lap ignored. clr -> IDLE + cnt_clr.
  - DONE: counter frozen at max. start and lap ignored. clr -> IDLE + cnt_clr.
- cnt_tick:
  - Equals the internal tick AND NOT cnt_at_max, registered.
  - Asserts exactly one cycle after the prescaler reaches TICK_DIV-1.
  - Never asserts in two consecutive cycles when TICK_DIV >= 2.
- cnt_clr: registered, asserts the cycle after the clr pulse, for 1 cycle. The prescaler resets on the same edge.
- disp_hold: registered from next-state == LAP; 0 in all other states.
- state and running are registered FSM outputs.
- Reset mid-operation: immediate return to IDLE. Any in-progress debounce count is lost; a button held through reset release must satisfy DB_CYC again.

Optional Feature:
LAP_AUTO_RELEASE_EN
- Defined: a tick counter (width clog2(LAP_HOLD_TICKS+1)) clears on LAP entry and increments on each cnt_tick in LAP. At LAP_HOLD_TICKS it forces LAP -> RUN, dropping disp_hold the next cycle.
  - A user lap or start pulse in the same cycle takes precedence.
  - Counter content is don't-care outside LAP.
- Undefined: LAP persists until a lap, start or clr pulse. No extra logic is generated.

Test Plan:
Bench uses TICK_DIV=10, DB_CYC=4, LAP_HOLD_TICKS=3.
- Debounce: btn_start toggles every 2 cycles for 20 cycles, then held high 10 cycles -> exactly one start pulse, 6 cycles after the stable high begins. state goes 0->1.
- Tick cadence: RUN for 100 cycles, cnt_at_max=0 -> 10 cnt_tick pulses, spaced exactly 10 cycles apart. Start press -> PAUSE with 0 further ticks. Resume -> first tick arrives after the remaining prescaler count, not a full 10.
- Lap: RUN, then lap press -> disp_hold=1, state=3, ticks continue. Second lap -> disp_hold=0, state=1.
- Saturation: cnt_at_max=1 in RUN -> at the next prescaler wrap, state=4 and no cnt_tick. start ignored. clr -> cnt_clr one cycle, state=0.
- Priority: clr and start debounced pulses land in the same cycle during PAUSE -> state=0, cnt_clr=1, no RUN.
- Reset: reset driven low asynchronously mid-LAP -> state=0, disp_hold=0 and cnt_tick=0 immediately. With LAP_AUTO_RELEASE_EN: 3 ticks in LAP -> auto return to state=1.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Run-control sequencer for the millisecond stopwatch datapath. It conditions
// the three pushbuttons (2-flop synchronizer + debounce + press pulse), runs
// the IDLE/RUN/PAUSE/LAP/DONE state machine, generates the gated count tick
// from a prescaler, and drives the counter clear and the display freeze.
//
// Optional feature macro: LAP_AUTO_RELEASE_EN
//   When defined, a lap freeze releases by itself after LAP_HOLD_TICKS count
//   ticks spent in LAP. When undefined, LAP persists until a button press.
//
// Parameters:
//   TICK_DIV       clk cycles per count tick (>= 2)
//   DB_CYC         stable-level cycles needed to accept a button change (>= 1)
//   LAP_HOLD_TICKS ticks a lap freeze lasts before auto-release (>= 1)
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-low reset
//   btn_start   raw start/stop button, asynchronous, active-high
//   btn_lap     raw lap button, asynchronous, active-high
//   btn_clr     raw clear button, asynchronous, active-high
//   cnt_at_max  datapath count is at its maximum value
//   cnt_tick    one-cycle increment enable to the counter
//   cnt_clr     one-cycle synchronous clear to the counter
//   disp_hold   display shows a frozen value while high (LAP)
//   state       encoded FSM state (IDLE=0, RUN=1, PAUSE=2, LAP=3, DONE=4)
//   running     high in RUN or LAP
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
   parameter int unsigned TICK_DIV       = 100000,
   parameter int unsigned DB_CYC         = 1000000,
   parameter int unsigned LAP_HOLD_TICKS = 3000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_start,
   input  logic       btn_lap,
   input  logic       btn_clr,
   input  logic       cnt_at_max,
   output logic       cnt_tick,
   output logic       cnt_clr,
   output logic       disp_hold,
   output logic [2:0] state,
   output logic       running
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned DW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYC - 1);

   localparam int BTN_START = 0;
   localparam int BTN_LAP   = 1;
   localparam int BTN_CLR   = 2;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_PAUSE = 3'd2,
      S_LAP   = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   // Parameter sanity checks, evaluated at elaboration only.
   if (TICK_DIV < 2) begin : g_bad_tick_div
      $error("stopwatch_ctrl: TICK_DIV must be at least 2");
   end
   if (DB_CYC < 1) begin : g_bad_db_cyc
      $error("stopwatch_ctrl: DB_CYC must be at least 1");
   end
   if (LAP_HOLD_TICKS < 1) begin : g_bad_lap_hold
      $error("stopwatch_ctrl: LAP_HOLD_TICKS must be at least 1");
   end

   // ---------------------------------------------------------------------------
   // Input conditioning
   // ---------------------------------------------------------------------------
   logic [2:0]          raw;
   logic [2:0]          sync1_q, sync2_q;
   logic [2:0]          db_lvl_q, db_lvl_d;
   logic [2:0][DW-1:0]  db_cnt_q, db_cnt_d;
   logic [2:0]          press_q, press_d;

   assign raw = {btn_clr, btn_lap, btn_start};

   // The debounced level follows the synced input only after DB_CYC
   // consecutive mismatching cycles; any matching cycle restarts the count.
   // A press pulse is produced on the accepted 0->1 change only.
   always_comb begin
      db_lvl_d = db_lvl_q;
      db_cnt_d = db_cnt_q;
      press_d  = '0;
      for (int i = 0; i < 3; i++) begin
         if (sync2_q[i] != db_lvl_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               db_cnt_d[i] = '0;
               db_lvl_d[i] = sync2_q[i];
               press_d[i]  = sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
         end else begin
            db_cnt_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         db_lvl_q <= '0;
         db_cnt_q <= '0;
         press_q  <= '0;
      end else begin
         sync1_q  <= raw;
         sync2_q  <= sync1_q;
         db_lvl_q <= db_lvl_d;
         db_cnt_q <= db_cnt_d;
         press_q  <= press_d;
      end
   end

   // Same-cycle presses: clear beats start, start beats lap.
   logic pulse_clr, pulse_start, pulse_lap;

   assign pulse_clr   = press_q[BTN_CLR];
   assign pulse_start = press_q[BTN_START] & ~press_q[BTN_CLR];
   assign pulse_lap   = press_q[BTN_LAP] & ~press_q[BTN_START] & ~press_q[BTN_CLR];

   // ---------------------------------------------------------------------------
   // Prescaler, state machine and registered outputs
   // ---------------------------------------------------------------------------
   state_e          state_q, state_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic            cnt_tick_q, cnt_clr_q, disp_hold_q, running_q;
   logic            counting;
   logic            tick_int;
   logic            lap_expired;

   assign counting = (state_q == S_RUN) || (state_q == S_LAP);
   assign tick_int = counting && (presc_q == PRESC_LAST);

`ifdef LAP_AUTO_RELEASE_EN
   localparam int unsigned LW = $clog2(LAP_HOLD_TICKS + 1);
   localparam logic [LW-1:0] LAP_LAST = LW'(LAP_HOLD_TICKS);

   logic [LW-1:0] lap_cnt_q, lap_cnt_d;

   // Held at zero outside LAP, so it starts from zero on every LAP entry.
   always_comb begin
      lap_cnt_d = lap_cnt_q;
      if (state_q != S_LAP) begin
         lap_cnt_d = '0;
      end else if (cnt_tick_q && (lap_cnt_q != LAP_LAST)) begin
         lap_cnt_d = lap_cnt_q + 1'b1;
      end
   end

   assign lap_expired = (state_q == S_LAP) && (lap_cnt_q == LAP_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lap_cnt_q <= '0;
      end else begin
         lap_cnt_q <= lap_cnt_d;
      end
   end
`else
   assign lap_expired = 1'b0;
`endif

   // Reaching the maximum on a tick ends the run ahead of any start/lap
   // press in the same cycle; only clear overrides it.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (pulse_start) state_d = S_RUN;
         end
         S_RUN: begin
            if (tick_int && cnt_at_max) state_d = S_DONE;
            else if (pulse_start)       state_d = S_PAUSE;
            else if (pulse_lap)         state_d = S_LAP;
         end
         S_LAP: begin
            if (tick_int && cnt_at_max)       state_d = S_DONE;
            else if (pulse_start)             state_d = S_PAUSE;
            else if (pulse_lap || lap_expired) state_d = S_RUN;
         end
         S_PAUSE: begin
            if (pulse_start) state_d = S_RUN;
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (pulse_clr) state_d = S_IDLE;
   end

   // PAUSE keeps the fractional count so a resume finishes the current tick.
   always_comb begin
      presc_d = presc_q;
      if (pulse_clr) begin
         presc_d = '0;
      end else if (counting) begin
         presc_d = tick_int ? '0 : presc_q + 1'b1;
      end else if (state_q != S_PAUSE) begin
         presc_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         presc_q     <= '0;
         cnt_tick_q  <= 1'b0;
         cnt_clr_q   <= 1'b0;
         disp_hold_q <= 1'b0;
         running_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         cnt_tick_q  <= tick_int & ~cnt_at_max;
         cnt_clr_q   <= pulse_clr;
         disp_hold_q <= (state_d == S_LAP);
         running_q   <= (state_d == S_RUN) || (state_d == S_LAP);
      end
   end

   assign state     = state_q;
   assign cnt_tick  = cnt_tick_q;
   assign cnt_clr   = cnt_clr_q;
   assign disp_hold = disp_hold_q;
   assign running   = running_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Bench for stopwatch_ctrl with TICK_DIV=10, DB_CYC=4, LAP_HOLD_TICKS=3.
// Expected cnt_tick cycle numbers are queued when a run phase is started and
// consumed by a monitor as ticks appear; state-level expectations are
// checked inline by each scenario task.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

   localparam int TICK_DIV       = 10;
   localparam int DB_CYC         = 4;
   localparam int LAP_HOLD_TICKS = 3;
   // Raw press driven before edge 1 -> press pulse after edge 2+DB_CYC ->
   // state change at the following edge.
   localparam int PRESS_LAT      = 2 + DB_CYC + 1;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RUN   = 3'd1;
   localparam logic [2:0] ST_PAUSE = 3'd2;
   localparam logic [2:0] ST_LAP   = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam logic [2:0] M_START = 3'b001;
   localparam logic [2:0] M_LAP   = 3'b010;
   localparam logic [2:0] M_CLR   = 3'b100;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       btn_start = 1'b0;
   logic       btn_lap = 1'b0;
   logic       btn_clr = 1'b0;
   logic       cnt_at_max = 1'b0;
   logic       cnt_tick;
   logic       cnt_clr;
   logic       disp_hold;
   logic [2:0] state;
   logic       running;

   int         vectors = 0;
   int         errors = 0;
   int         cyc = 0;
   bit         track = 1'b0;
   logic [31:0] exp_q[$];

   stopwatch_ctrl #(
      .TICK_DIV       (TICK_DIV),
      .DB_CYC         (DB_CYC),
      .LAP_HOLD_TICKS (LAP_HOLD_TICKS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .btn_start  (btn_start),
      .btn_lap    (btn_lap),
      .btn_clr    (btn_clr),
      .cnt_at_max (cnt_at_max),
      .cnt_tick   (cnt_tick),
      .cnt_clr    (cnt_clr),
      .disp_hold  (disp_hold),
      .state      (state),
      .running    (running)
   );

   // ---------------------------------------------------------------------------
   // Clock / cycle count / watchdog
   // ---------------------------------------------------------------------------
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------------
   // Tick scoreboard: every observed tick must match the head of exp_q
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      logic [31:0] exp_c;
      if (track && reset && cnt_tick) begin
         vectors++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL tick_unexpected: tick at cycle %0d, expected none", cyc);
         end else begin
            exp_c = exp_q.pop_front();
            if (32'(cyc) !== exp_c) begin
               errors++;
               $display("FAIL tick_time: tick at cycle %0d, expected cycle %0d", cyc, exp_c);
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks (called and returning at a falling edge)
   // ---------------------------------------------------------------------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Hold the masked buttons until the resulting state change has happened,
   // then release them.
   task automatic press(input logic [2:0] mask);
      btn_start = mask[0];
      btn_lap   = mask[1];
      btn_clr   = mask[2];
      repeat (PRESS_LAT) @(negedge clk);
      btn_start = 1'b0;
      btn_lap   = 1'b0;
      btn_clr   = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      idle(2);
      vectors++;
      if (state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state, ST_IDLE); end
      vectors++;
      if (cnt_tick !== 1'b0) begin errors++; $display("FAIL reset_cnt_tick: got %b expected 0", cnt_tick); end
      vectors++;
      if (cnt_clr !== 1'b0) begin errors++; $display("FAIL reset_cnt_clr: got %b expected 0", cnt_clr); end
      vectors++;
      if (disp_hold !== 1'b0) begin errors++; $display("FAIL reset_disp_hold: got %b expected 0", disp_hold); end
      vectors++;
      if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", running); end
      reset = 1'b1;
      idle(3);
      vectors++;
      if (state !== ST_IDLE) begin errors++; $display("FAIL reset_release_state: got %0d expected %0d", state, ST_IDLE); end
   endtask

   task automatic test_debounce();
      logic [2:0] exp_s;
      // Bounce: 2-cycle segments never satisfy DB_CYC=4.
      for (int i = 0; i < 10; i++) begin
         btn_start = (i % 2 == 0);
         repeat (2) begin
            @(negedge clk);
            vectors++;
            if (state !== ST_IDLE) begin errors++; $display("FAIL debounce_bounce: state %0d expected %0d", state, ST_IDLE); end
         end
      end
      btn_start = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         exp_s = (k >= PRESS_LAT) ? ST_RUN : ST_IDLE;
         vectors++;
         if (state !== exp_s) begin errors++; $display("FAIL debounce_stable k=%0d: state %0d expected %0d", k, state, exp_s); end
      end
      btn_start = 1'b0;
      idle(10);
      vectors++;
      if (state !== ST_RUN) begin errors++; $display("FAIL debounce_single_pulse: state %0d expected %0d", state, ST_RUN); end
      press(M_CLR);
      vectors++;
      if (state !== ST_IDLE) begin errors++; $display("FAIL debounce_clr_state: state %0d expected %0d", state, ST_IDLE); end
      vectors++;
      if (cnt_clr !== 1'b1) begin errors++; $display("FAIL debounce_cnt_clr: got %b expected 1", cnt_clr); end
      idle(1);
      vectors++;
      if (cnt_clr !== 1'b0) begin errors++; $display("FAIL debounce_cnt_clr_width: got %b expected 0", cnt_clr); end
      idle(8);
   endtask

   task automatic test_tick_cadence();
      int e, p, r;
      track = 1'b1;
      press(M_START);
      e = cyc;
      vectors++;
      if (state !== ST_RUN) begin errors++; $display("FAIL cadence_run: state %0d expected %0d", state, ST_RUN); end
      for (int i = 1; i <= 10; i++) exp_q.push_back(32'(e + i * TICK_DIV));
      // Pause lands 5 cycles into the 11th tick period.
      wait_until(e + 98);
      press(M_START);
      p = cyc;
      vectors++;
      if (state !== ST_PAUSE) begin errors++; $display("FAIL cadence_pause: state %0d expected %0d", state, ST_PAUSE); end
      wait_until(p + 30);
      vectors++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL cadence_ticks_missing: %0d pending expected 0", exp_q.size()); end
      press(M_START);
      r = cyc;
      vectors++;
      if (state !== ST_RUN) begin errors++; $display("FAIL cadence_resume: state %0d expected %0d", state, ST_RUN); end
      // Resume finishes the interrupted period: 10 - 5 cycles to the next tick.
      exp_q.push_back(32'(r + 5));
      exp_q.push_back(32'(r + 15));
      wait_until(r + 16);
      press(M_CLR);
      vectors++;
      if (state !== ST_IDLE) begin errors++; $display("FAIL cadence_clr: state %0d expected %0d", state, ST_IDLE); end
      vectors++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL cadence_resume_ticks: %0d pending expected 0", exp_q.size()); end
      track = 1'b0;
      exp_q.delete();
      idle(8);
   endtask

   task automatic test_lap();
      int e;
      track = 1'b1;
      press(M_START);
      e = cyc;
      exp_q.push_back(32'(e + 10));
      exp_q.push_back(32'(e + 20));
      exp_q.push_back(32'(e + 30));
      wait_until(e + 5);
      press(M_LAP);
      vectors++;
      if (state !== ST_LAP) begin errors++; $display("FAIL lap_enter_state: state %0d expected %0d", state, ST_LAP); end
      vectors++;
      if (disp_hold !== 1'b1) begin errors++; $display("FAIL lap_enter_hold: got %b expected 1", disp_hold); end
      vectors++;
      if (running !== 1'b1) begin errors++; $display("FAIL lap_running: got %b expected 1", running); end
      wait_until(e + 21);
      vectors++;
      if (disp_hold !== 1'b1) begin errors++; $display("FAIL lap_hold_mid: got %b expected 1", disp_hold); end
      press(M_LAP);
      vectors++;
      if (state !== ST_RUN) begin errors++; $display("FAIL lap_exit_state: state %0d expected %0d", state, ST_RUN); end
      vectors++;
      if (disp_hold !== 1'b0) begin errors++; $display("FAIL lap_exit_hold: got %b expected 0", disp_hold); end
      press(M_CLR);
      vectors++;
      if (state !== ST_IDLE) begin errors++; $display("FAIL lap_clr: state %0d expected %0d", state, ST_IDLE); end
      vectors++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL lap_ticks_missing: %0d pending expected 0", exp_q.size()); end
      track = 1'b0;
      exp_q.delete();
      idle(8);
   endtask

   task automatic test_saturation();
      int e;
      track = 1'b1;  // no ticks queued: any tick is unexpected
      press(M_START);
      e = cyc;
      wait_until(e + 3);
      cnt_at_max = 1'b1;
      wait_until(e + 9);
      vectors++;
      if (state !== ST_RUN) begin errors++; $display("FAIL sat_before_wrap: state %0d expected %0d", state, ST_RUN); end
      wait_until(e + 10);
      vectors++;
      if (state !== ST_DONE) begin errors++; $display("FAIL sat_done: state %0d expected %0d", state, ST_DONE); end
      vectors++;
      if (running !== 1'b0) begin errors++; $display("FAIL sat_running: got %b expected 0", running); end
      idle(8);
      press(M_START);
      vectors++;
      if (state !== ST_DONE) begin errors++; $display("FAIL sat_start_ignored: state %0d expected %0d", state, ST_DONE); end
      idle(8);
      press(M_LAP);
      vectors++;
      if (state !== ST_DONE) begin errors++; $display("FAIL sat_lap_ignored: state %0d expected %0d", state, ST_DONE); end
      press(M_CLR);
      vectors++;
      if (state !== ST_IDLE) begin errors++; $display("FAIL sat_clr_state: state %0d expected %0d", state, ST_IDLE); end
      vectors++;
      if (cnt_clr !== 1'b1) begin errors++; $display("FAIL sat_cnt_clr: got %b expected 1", cnt_clr); end
      idle(1);
      vectors++;
      if (cnt_clr !== 1'b0) begin errors++; $display("FAIL sat_cnt_clr_width: got %b expected 0", cnt_clr); end
      cnt_at_max = 1'b0;
      track = 1'b0;
      idle(8);
   endtask

   task automatic test_priority();
      press(M_START);
      idle(8);
      press(M_START);
      vectors++;
      if (state !== ST_PAUSE) begin errors++; $display("FAIL prio_pause: state %0d expected %0d", state, ST_PAUSE); end
      idle(8);
      press(M_LAP);
      vectors++;
      if (state !== ST_PAUSE) begin errors++; $display("FAIL prio_lap_ignored: state %0d expected %0d", state, ST_PAUSE); end
      idle(8);
      press(M_CLR | M_START);
      vectors++;
      if (state !== ST_IDLE) begin errors++; $display("FAIL prio_clr_wins: state %0d expected %0d", state, ST_IDLE); end
      vectors++;
      if (cnt_clr !== 1'b1) begin errors++; $display("FAIL prio_cnt_clr: got %b expected 1", cnt_clr); end
      idle(10);
      vectors++;
      if (state !== ST_IDLE) begin errors++; $display("FAIL prio_no_run: state %0d expected %0d", state, ST_IDLE); end
      idle(2);
   endtask

   task automatic test_reset_mid_lap();
      logic [2:0] exp_s;
      press(M_START);
      idle(8);
      press(M_LAP);
      vectors++;
      if (state !== ST_LAP) begin errors++; $display("FAIL rst_setup_lap: state %0d expected %0d", state, ST_LAP); end
      idle(8);
      // Partial debounce progress that reset must discard.
      btn_start = 1'b1;
      idle(3);
      #2 reset = 1'b0;
      #1;
      vectors++;
      if (state !== ST_IDLE) begin errors++; $display("FAIL rst_async_state: state %0d expected %0d", state, ST_IDLE); end
      vectors++;
      if (disp_hold !== 1'b0) begin errors++; $display("FAIL rst_async_hold: got %b expected 0", disp_hold); end
      vectors++;
      if (cnt_tick !== 1'b0) begin errors++; $display("FAIL rst_async_tick: got %b expected 0", cnt_tick); end
      vectors++;
      if (running !== 1'b0) begin errors++; $display("FAIL rst_async_running: got %b expected 0", running); end
      idle(2);
      reset = 1'b1;
      // Button held through reset must qualify from scratch.
      for (int k = 1; k <= PRESS_LAT + 1; k++) begin
         @(negedge clk);
         exp_s = (k >= PRESS_LAT) ? ST_RUN : ST_IDLE;
         vectors++;
         if (state !== exp_s) begin errors++; $display("FAIL rst_requalify k=%0d: state %0d expected %0d", k, state, exp_s); end
      end
      btn_start = 1'b0;
      idle(8);
      press(M_CLR);
      vectors++;
      if (state !== ST_IDLE) begin errors++; $display("FAIL rst_final_clr: state %0d expected %0d", state, ST_IDLE); end
      idle(8);
   endtask

`ifdef LAP_AUTO_RELEASE_EN
   task automatic test_lap_auto_release();
      int e;
      int seen;
      press(M_START);
      e = cyc;
      idle(8);
      press(M_LAP);
      vectors++;
      if (state !== ST_LAP) begin errors++; $display("FAIL auto_lap_enter: state %0d expected %0d", state, ST_LAP); end
      // LAP entered at e+15; ticks in LAP at e+20, e+30, e+40; counter hits
      // 3 on edge e+41, so RUN is entered on edge e+42.
      seen = -1;
      for (int k = 0; k < 60 && seen < 0; k++) begin
         @(negedge clk);
         if (state === ST_RUN) seen = cyc;
      end
      vectors++;
      if (seen != e + 42) begin errors++; $display("FAIL auto_release_time: cycle %0d expected %0d", seen, e + 42); end
      vectors++;
      if (disp_hold !== 1'b0) begin errors++; $display("FAIL auto_release_hold: got %b expected 0", disp_hold); end
      idle(2);
      press(M_CLR);
      vectors++;
      if (state !== ST_IDLE) begin errors++; $display("FAIL auto_clr: state %0d expected %0d", state, ST_IDLE); end
      idle(8);
   endtask
`endif

   // ---------------------------------------------------------------------------
   // Sequence and report
   // ---------------------------------------------------------------------------
   initial begin
      test_reset();
      test_debounce();
      test_tick_cadence();
      test_lap();
      test_saturation();
      test_priority();
      test_reset_mid_lap();
`ifdef LAP_AUTO_RELEASE_EN
      test_lap_auto_release();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
